clk_meas: RTL and testbench

CLK_MEAS -- requirements
Module: clk_meas

---
 rtl/clk_meas.sv | 185 ++++++++++++++++++
 tb/tb_clk_meas.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_meas.sv
// clk_meas: measures the period and high time of sig_in in clock_in cycles.
// sig_in is synchronized, and its rising edges open and close each measurement.
// A wait timer aborts the measurement when no edge arrives in time.
// Optional feature macro: CLK_MEAS_CONTINUOUS_EN. It gives back-to-back measurements
// while start is held high.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start
// ARM     | waiting for the opening synchronized rise
// MEASURE | counting cycles and high cycles until the closing rise
// DONE    | results registered, valid high for this single cycle
module clk_meas #(
    parameter int               WIDTH   = 28,
    parameter logic [WIDTH-1:0] TIMEOUT = 28'hFFFFFFF
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             start,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Reloading with TIMEOUT-1 and stopping at zero allows exactly TIMEOUT edge-free cycles.
    localparam logic [WIDTH-1:0] WAIT_LOAD = TIMEOUT - WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic             w_rise;
    logic [WIDTH-1:0] w_hinc;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_hcnt;
    logic [WIDTH-1:0] r_wait;
    logic             w_wait_tc;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high;
    logic             r_valid;
    logic             r_timeout;
    logic             w_valid_nxt;
    logic             w_timeout_nxt;

    assign w_rise    = r_sync2 & ~r_sync3;
    assign w_hinc    = {{(WIDTH-1){1'b0}}, r_sync2};
    assign w_wait_tc = (r_wait == '0);

    assign period    = r_period;
    assign high_time = r_high;
    assign valid     = r_valid;
    assign timeout   = r_timeout;
    assign busy      = (r_state == S_ARM) || (r_state == S_MEASURE);

    // The first two flops synchronize sig_in. The third flop delays it for edge detection.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // State register
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and the one-cycle result/abort pulses. A rise takes priority over the timer.
    always_comb begin
        w_state_nxt   = r_state;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (w_rise) begin
                    w_state_nxt = S_MEASURE;
                end else if (w_wait_tc) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = 1'b1;
                end
            end
            S_MEASURE: begin
                if (w_rise) begin
                    w_state_nxt = S_DONE;
                    w_valid_nxt = 1'b1;
                end else if (w_wait_tc) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = 1'b1;
                end
            end
            S_DONE: begin
`ifdef CLK_MEAS_CONTINUOUS_EN
                w_state_nxt = start ? S_MEASURE : S_IDLE;
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counters, wait timer and result registers.
    // Every rise restarts the counts, so in continuous mode the closing rise of one
    // measurement is also the opening rise of the next. The DONE cycle is then counted
    // as the first cycle that follows that opening rise.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_hcnt    <= '0;
            r_wait    <= '0;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
            case (r_state)
                S_IDLE: begin
                    r_wait <= WAIT_LOAD;
                end
                S_ARM: begin
                    if (w_rise) begin
                        r_cnt  <= '0;
                        r_hcnt <= w_hinc;
                        r_wait <= WAIT_LOAD;
                    end else if (!w_wait_tc) begin
                        r_wait <= r_wait - WIDTH'(1);
                    end
                end
                S_MEASURE: begin
                    if (w_rise) begin
                        r_period <= r_cnt + WIDTH'(1);
                        r_high   <= r_hcnt;
                        r_cnt    <= '0;
                        r_hcnt   <= w_hinc;
                        r_wait   <= WAIT_LOAD;
                    end else begin
                        r_cnt  <= r_cnt + WIDTH'(1);
                        r_hcnt <= r_hcnt + w_hinc;
                        if (!w_wait_tc) begin
                            r_wait <= r_wait - WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_cnt  <= r_cnt + WIDTH'(1);
                    r_hcnt <= r_hcnt + w_hinc;
                    if (!w_wait_tc) begin
                        r_wait <= r_wait - WIDTH'(1);
                    end
                end
                default: begin
                    r_wait <= WAIT_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_meas.sv
// tb_clk_meas: scoreboard bench for clk_meas.
// The driver pushes the expected outcome of each measurement into a queue. For a
// square wave of n cycles with h high cycles, that outcome is a result of (n, h) when
// n <= TIMEOUT. It is a timeout when n > TIMEOUT or the signal is held low.
// The monitor pops and compares the queue whenever valid or timeout appears.
module tb_clk_meas;
    localparam int WIDTH = 28;
    localparam int TO    = 20;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             sig_in = 1'b0;
    logic             start  = 1'b0;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             busy;
    logic             timeout;

    clk_meas #(.WIDTH(WIDTH), .TIMEOUT(28'(TO))) dut (
        .clock_in (clk),
        .reset_n  (rst_n),
        .sig_in   (sig_in),
        .start    (start),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_to;
        bit chk_lat;
        int per;
        int hi;
        int gap;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   total = 0;
    int   bad = 0;
    int   resp_cnt = 0;
    int   busy_run = 0;
    int   cyc = 0;
    int   last_valid_cyc = 0;
    int   last_per = 0;
    int   last_hi = 0;
    int   wave_n = 1;
    int   wave_h = 0;
    int   ph = 0;
    bit   ph_rst = 1'b0;

    always @(posedge clk) cyc++;

    // Square-wave generator: sig_in is high for wave_h of every wave_n cycles. It changes on the falling edge.
    always @(negedge clk) begin
        if (ph_rst) begin
            ph     = 0;
            ph_rst = 1'b0;
        end
        sig_in = (ph < wave_h);
        ph     = (ph + 1) % wave_n;
    end

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge and compares each response with the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid || timeout) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp valid=%0b timeout=%0b period=%0d required=no response",
                             valid, timeout, period);
                end else begin
                    m_e = q.pop_front();
                    chk("kind_valid", valid, !m_e.is_to);
                    chk("kind_timeout", timeout, m_e.is_to);
                    if (!m_e.is_to) begin
                        chk("period", period, m_e.per);
                        chk("high_time", high_time, m_e.hi);
                        chk("busy_on_done", busy, 0);
                        if (m_e.gap != 0) chk("valid_gap", cyc - last_valid_cyc, m_e.gap);
                        last_per = m_e.per;
                        last_hi  = m_e.hi;
                    end else begin
                        chk("period_hold", period, last_per);
                        chk("high_hold", high_time, last_hi);
                        if (m_e.chk_lat) chk("timeout_latency", busy_run, TO);
                    end
                end
                if (valid) last_valid_cyc = cyc;
                resp_cnt++;
            end
            busy_run = busy ? busy_run + 1 : 0;
        end else begin
            busy_run = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_wave(input int n, input int h);
        wave_n = n;
        wave_h = h;
        ph_rst = 1'b1;
        repeat (n + 5) tick();
    endtask

    task automatic push_exp(input int n, input int h, input int gap);
        exp_t e;
        e.per = n;
        e.hi  = h;
        e.gap = gap;
        e.is_to   = (h == 0) || (n > TO);
        e.chk_lat = (h == 0);
        q.push_back(e);
    endtask

    task automatic wait_resp(input int target, input string name);
        int k;
        k = 0;
        while (resp_cnt < target && k < 400) begin
            tick();
            k++;
        end
        chk(name, resp_cnt >= target, 1);
    endtask

    task automatic meas(input int n, input int h);
        int tgt;
        set_wave(n, h);
        push_exp(n, h, 0);
        tgt   = resp_cnt + 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_resp(tgt, "meas_wait");
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_high_time"}, high_time, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        int tgt;
        int n;
        int h;
        int k;
        logic prev;

        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        meas(4, 2);
        meas(2, 1);
        meas(1, 0);
        meas(20, 10);
        meas(21, 10);

        // A repeated start during a measurement must be ignored.
        set_wave(8, 4);
        push_exp(8, 4, 0);
        tgt   = resp_cnt + 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_resp(tgt, "repulse_wait");
        repeat (20) tick();

        // Start held high.
        set_wave(10, 5);
`ifdef CLK_MEAS_CONTINUOUS_EN
        push_exp(10, 5, 0);
        for (int i = 0; i < 3; i++) push_exp(10, 5, 10);
        tgt = resp_cnt + 4;
`else
        push_exp(10, 5, 0);
        tgt = resp_cnt + 1;
`endif
        start = 1'b1;
        wait_resp(tgt, "held_start_wait");
        start = 1'b0;
        repeat (30) tick();

        // Reset pulse in the middle of a measurement. Start is aligned with a sig_in rise.
        set_wave(20, 10);
        prev = sig_in;
        k    = 0;
        tick();
        while (!(sig_in && !prev) && k < 50) begin
            prev = sig_in;
            tick();
            k++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("busy_before_reset", busy, 1);
        #1 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        tick();
        rst_n    = 1'b1;
        last_per = 0;
        last_hi  = 0;
        repeat (40) tick();
        meas(6, 3);

        for (int i = 0; i < 10; i++) begin
            n = $urandom_range(24, 2);
            h = $urandom_range(n - 1, 1);
            meas(n, h);
        end
        meas(1, 0);

        repeat (5) tick();
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
